// File: rtl/mmio_io_ctrl.sv
// Memory-mapped switch/LED block: synchronised and debounced switch inputs,
// an LED output register, sticky change flags with write-1-to-clear, and a
// per-bit interrupt enable feeding a registered irq.
module mmio_io_ctrl #(
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned LED_WIDTH       = 16,
  parameter logic [31:0] BASE_ADDR       = 32'd4096,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [SW_WIDTH-1:0]  sw_in,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic                 wren,
  output logic                 hit,
  output logic [31:0]          rdata,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sync_q, sync_d;
  logic [SW_WIDTH-1:0]  cand_q, cand_d;
  logic [SW_WIDTH-1:0]  stab_q, stab_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [SW_WIDTH-1:0]  chg_q, chg_d;
  logic [SW_WIDTH-1:0]  ien_q, ien_d;
  logic                 irq_q, irq_d;

  logic [SW_WIDTH-1:0] sync_out;
  logic [31:0]         offset;
  logic [1:0]          sel;
  logic                wr_en;
  logic                unused_wdata;

  // The offset subtraction wraps for addresses below the base, so a single
  // unsigned compare covers both ends of the window.
  assign offset       = addr - BASE_ADDR;
  assign hit          = (offset < 32'd4);
  assign sel          = offset[1:0];
  assign wr_en        = wren & hit;
  assign sync_out     = sync_q[SYNC_STAGES-1];
  assign led_out      = led_q;
  assign irq          = irq_q;
  assign unused_wdata = ^wdata;

  // Switch synchroniser chain: raw levels enter stage 0 and shift along.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = sw_in;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Debounce: any new sample restarts the count; the stable value is taken
  // once the candidate has held long enough. The counter saturates.
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    cnt_d  = cnt_q;
    if (sync_out != cand_q) begin
      cand_d = sync_out;
      cnt_d  = '0;
      if (DEBOUNCE_CYCLES == 1) stab_d = sync_out;
    end else if (cand_q != stab_q) begin
      if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_LAST) stab_d = cand_q;
    end
  end

  // Register writes; a change-flag set wins over a coincident clear.
  always_comb begin
    led_d = led_q;
    ien_d = ien_q;
    chg_d = chg_q;
    if (wr_en && sel == 2'd1) led_d = wdata[LED_WIDTH-1:0];
    if (wr_en && sel == 2'd3) ien_d = wdata[SW_WIDTH-1:0];
    if (wr_en && sel == 2'd2) chg_d = chg_q & ~wdata[SW_WIDTH-1:0];
    chg_d = chg_d | (stab_q ^ stab_d);
    irq_d = |(chg_q & ien_q);
  end

  // Read mux, zero-extended, zero when the address misses the window.
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (sel)
        2'd0:    rdata[SW_WIDTH-1:0]  = stab_q;
        2'd1:    rdata[LED_WIDTH-1:0] = led_q;
        2'd2:    rdata[SW_WIDTH-1:0]  = chg_q;
        default: rdata[SW_WIDTH-1:0]  = ien_q;
      endcase
    end
  end

  // State registers, all cleared asynchronously by reset low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cand_q <= '0;
      stab_q <= '0;
      cnt_q  <= '0;
      led_q  <= '0;
      chg_q  <= '0;
      ien_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cand_q <= cand_d;
      stab_q <= stab_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      chg_q  <= chg_d;
      ien_q  <= ien_d;
      irq_q  <= irq_d;
    end
  end

endmodule
